mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//  Memory-side responder for the 8-bit multicycle MIPS core: byte-wide RAM answering the core's
//  adr/writedata/memwrite bus with combinational read data. Adds a host load/dump port (valid/ready)
//  and owns the core's reset: core held in reset while host loads/inspects memory, released on RUN.
// PARAMETERS
//  WIDTH  8           data and address width (matches core WIDTH)
//  DEPTH  2**WIDTH    bytes of storage; address wraps modulo DEPTH
// PORTS
//  clk            in   1      clock
//  reset_n        in   1      asynchronous, active-low reset
//  cpu_adr        in   WIDTH  core address (core adr)
//  cpu_writedata  in   WIDTH  core store data
//  cpu_memwrite   in   1      core store strobe (core controller memwrite)
//  cpu_memdata    out  WIDTH  read data to core memdata
//  cpu_reset      out  1      registered active-high sync reset to core
//  host_valid     in   1      host command valid
//  host_ready     out  1      host command accepted when valid&ready
//  host_op        in   2      00 SETPTR, 01 WRBYTE, 10 RDBYTE, 11 RUN
//  host_wdata     in   WIDTH  pointer value (SETPTR) or byte (WRBYTE)
//  halt           in   1      stop core, return to HOLD
//  rsp_valid      out  1      read response valid
//  rsp_ready      in   1      read response accepted when valid&ready
//  rsp_data       out  WIDTH  read response byte
//  running        out  1      1 in RUN
//  run_cycles     out  16     cycles spent in current/last RUN, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (async, reset_n=0): state HOLD, ptr=0, cpu_reset=1, running=0, rsp_valid=0, rsp_data=0,
//   run_cycles=0; host_ready=1 once out of reset. RAM contents NOT cleared.
//  cpu_memdata = RAM[cpu_adr] combinationally in every state (core latches on same edge as adr).
//  FSM states HOLD, RUN, RDRSP:
//   HOLD: host_ready=1. On host_valid:
//    SETPTR: ptr<=host_wdata; stay HOLD.
//    WRBYTE: RAM[ptr]<=host_wdata; ptr<=ptr+1 (wrap DEPTH-1 -> 0); stay HOLD.
//    RDBYTE: rsp_data<=RAM[ptr]; ptr<=ptr+1 (wrap); rsp_valid<=1; -> RDRSP.
//    RUN: -> RUN; run_cycles<=0; cpu_reset<=0 (core leaves reset 1 cycle after acceptance).
//   RDRSP: host_ready=0; rsp_valid, rsp_data held stable until rsp_ready; on rsp_valid&rsp_ready
//    rsp_valid<=0, -> HOLD (next command accepted the following cycle).
//   RUN: host_ready=0, host_valid ignored. cpu_memwrite=1 -> RAM[cpu_adr]<=cpu_writedata at posedge.
//    run_cycles increments each RUN cycle, saturates. halt=1 -> HOLD, cpu_reset<=1, running<=0.
//  cpu_memwrite ignored outside RUN. halt ignored outside RUN.
//  Simultaneous halt & cpu_memwrite in RUN: the store commits; transition to HOLD same edge.
//  Only one RAM writer per state (host in HOLD, core in RUN): no write arbitration needed.
//  reset_n mid-RUN or mid-RDRSP: core forced to reset immediately, pending response dropped,
//   RAM retained.
//  Host write-then-read of same address: RDBYTE returns written value (write commits before read).
//  All arithmetic unsigned WIDTH bits; ptr overflow wraps silently.
// STRUCTURE
//  Package mips_mem_pkg: typedef enum memstate_t {HOLD, RUN, RDRSP}; typedef enum host_op_t
//   {SETPTR=2'b00, WRBYTE=2'b01, RDBYTE=2'b10, RUNOP=2'b11}.
//  Sub-module byte_ram #(WIDTH, DEPTH): one sync write port, two async read ports
//   (cpu_adr, ptr); no reset. Write port muxed by state (host in HOLD, core in RUN).
//  FSM, ptr, rsp regs, run_cycles counter in top.
// TESTING
//  1 Reset; SETPTR 0x00; WRBYTE 0x20,0x07,0x00,0x80; SETPTR 0x00; RDBYTE x2 -> rsp 0x20 then 0x07, ptr=0x02.
//  2 SETPTR 0xFF; WRBYTE 0x11; WRBYTE 0x22 -> RAM[0xFF]=0x11, RAM[0x00]=0x22 (wrap).
//  3 RUN -> cpu_reset=0 next cycle, running=1, host_ready=0; host_valid WRBYTE 0x99 during RUN
//    -> no RAM change; cpu_memwrite adr 0x40 data 0x5A; halt; SETPTR 0x40; RDBYTE -> 0x5A.
//  4 RDBYTE with rsp_ready=0 for 5 cycles -> rsp_valid=1, rsp_data stable, host_ready=0; ptr
//    advanced only once.
//  5 halt and cpu_memwrite (adr 0x10, 0xA5) same cycle -> RAM[0x10]=0xA5, cpu_reset=1 next cycle;
//    run_cycles equals RUN cycle count.
//  6 reset_n pulse mid-RUN -> cpu_reset=1 immediately, running=0, ptr=0; readback of test-1 bytes intact.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS memory responder: FSM states and host command opcodes.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    RDRSP
  } memstate_t;

  typedef enum logic [1:0] {
    SETPTR = 2'b00,
    WRBYTE = 2'b01,
    RDBYTE = 2'b10,
    RUNOP  = 2'b11
  } host_op_t;

endpackage

// File: rtl/mips_mem_responder_byte_ram.sv
// Byte-wide storage: one synchronous write port, two asynchronous read ports, no reset.
module byte_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2**WIDTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [WIDTH-1:0] raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the multicycle MIPS core: byte RAM on the core bus, host load/dump port,
// and ownership of the core reset (held while the host works, released on RUN until halt).
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2**WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  input  logic             cpu_memwrite,
  output logic [WIDTH-1:0] cpu_memdata,
  output logic             cpu_reset,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [1:0]       host_op,
  input  logic [WIDTH-1:0] host_wdata,
  input  logic             halt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             running,
  output logic [15:0]      run_cycles
);

  memstate_t        state_q, state_d;
  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic [15:0]      run_cycles_q, run_cycles_d;

  logic             ram_we;
  logic [WIDTH-1:0] ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_ptr_data;
  logic [WIDTH-1:0] ptr_inc;

  byte_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (cpu_adr),
    .rdata_a (cpu_memdata),
    .raddr_b (ptr_q),
    .rdata_b (ram_ptr_data)
  );

  assign ptr_inc = (ptr_q == WIDTH'(DEPTH - 1)) ? '0 : ptr_q + WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    cpu_reset_d  = cpu_reset_q;
    run_cycles_d = run_cycles_q;
    ram_we       = 1'b0;
    ram_waddr    = ptr_q;
    ram_wdata    = host_wdata;
    host_ready   = 1'b0;

    case (state_q)
      HOLD: begin
        host_ready = 1'b1;
        if (host_valid) begin
          case (host_op_t'(host_op))
            SETPTR: ptr_d = host_wdata;
            WRBYTE: begin
              ram_we = 1'b1;
              ptr_d  = ptr_inc;
            end
            RDBYTE: begin
              rsp_data_d  = ram_ptr_data;
              rsp_valid_d = 1'b1;
              ptr_d       = ptr_inc;
              state_d     = RDRSP;
            end
            RUNOP: begin
              run_cycles_d = '0;
              cpu_reset_d  = 1'b0;
              state_d      = RUN;
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        // The core is the only RAM writer here; a store alongside halt still commits.
        ram_we    = cpu_memwrite;
        ram_waddr = cpu_adr;
        ram_wdata = cpu_writedata;
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 16'd1;
        if (halt) begin
          cpu_reset_d = 1'b1;
          state_d     = HOLD;
        end
      end

      RDRSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = HOLD;
        end
      end

      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HOLD;
      ptr_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      cpu_reset_q  <= 1'b1;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      cpu_reset_q  <= cpu_reset_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign running    = (state_q == RUN);
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: command tables, corner sequences, random traffic
// against a byte-array memory model.
module tb_mips_mem_responder;

  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_RUN = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] cpu_adr = '0;
  logic [7:0] cpu_writedata = '0;
  logic       cpu_memwrite = 1'b0;
  logic [7:0] cpu_memdata;
  logic       cpu_reset;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [1:0] host_op = '0;
  logic [7:0] host_wdata = '0;
  logic       halt = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       running;
  logic [15:0] run_cycles;

  mips_mem_responder #(.WIDTH(8), .DEPTH(256)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_adr       (cpu_adr),
    .cpu_writedata (cpu_writedata),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_memdata   (cpu_memdata),
    .cpu_reset     (cpu_reset),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .host_op       (host_op),
    .host_wdata    (host_wdata),
    .halt          (halt),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .running       (running),
    .run_cycles    (run_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents and host pointer.
  logic [7:0] mem_m [256];
  logic [7:0] ptr_m;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one host command starting at posedge+1; returns at posedge+1 after completion.
  task automatic host_cmd(input logic [1:0] op, input logic [7:0] wd, input int hold,
                          output logic [7:0] rd);
    int k;
    logic [7:0] exp;
    rd = '0;
    host_valid = 1'b1;
    host_op    = op;
    host_wdata = wd;
    k = 0;
    while (!host_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!host_ready) begin
      check("host_ready_wait", 32'(host_ready), 32'd1);
      host_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    host_valid = 1'b0;
    case (op)
      OP_SET: ptr_m = wd;
      OP_WR: begin
        mem_m[ptr_m] = wd;
        ptr_m++;
      end
      OP_RD: begin
        exp = mem_m[ptr_m];
        ptr_m++;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(exp));
        check("ready_in_rdrsp", 32'(host_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
          check("rsp_data_hold", 32'(rsp_data), 32'(exp));
          check("ready_hold", 32'(host_ready), 32'd0);
        end
        rd = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(host_ready), 32'd1);
      end
      default: begin
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check("run_running", 32'(running), 32'd1);
        check("run_ready", 32'(host_ready), 32'd0);
      end
    endcase
  endtask

  // RUN for n cycles; halt is raised on the last one.
  task automatic do_run(input int n, input bit stores, input bit poke, input bit fixed_last);
    logic [7:0] dummy;
    host_cmd(OP_RUN, 8'h00, 0, dummy);
    for (int i = 0; i < n; i++) begin
      cpu_adr       = 8'($urandom);
      cpu_writedata = 8'($urandom);
      cpu_memwrite  = stores && ($urandom_range(0, 1) == 1);
      halt          = (i == n - 1);
      if (fixed_last && i == n - 1) begin
        cpu_adr       = 8'h10;
        cpu_writedata = 8'hA5;
        cpu_memwrite  = 1'b1;
      end
      if (poke) begin
        host_valid = 1'b1;
        host_op    = OP_WR;
        host_wdata = 8'h99;
      end
      #1;
      check("cpu_memdata_run", 32'(cpu_memdata), 32'(mem_m[cpu_adr]));
      check("run_cycles_mid", 32'(run_cycles), 32'(i));
      @(posedge clk);
      if (cpu_memwrite) mem_m[cpu_adr] = cpu_writedata;
      #1;
      cpu_memwrite = 1'b0;
      halt         = 1'b0;
      host_valid   = 1'b0;
    end
    check("halt_running", 32'(running), 32'd0);
    check("halt_cpu_reset", 32'(cpu_reset), 32'd1);
    check("run_cycles", 32'(run_cycles), 32'(n));
    check("halt_ready", 32'(host_ready), 32'd1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t vecs [15];
    logic [7:0] rd;
    logic [7:0] first;
    int limit;

    vecs = '{
      '{OP_SET, 8'h00, 8'h00}, '{OP_WR, 8'h20, 8'h00}, '{OP_WR, 8'h07, 8'h00},
      '{OP_WR, 8'h00, 8'h00},  '{OP_WR, 8'h80, 8'h00}, '{OP_SET, 8'h00, 8'h00},
      '{OP_RD, 8'h00, 8'h20},  '{OP_RD, 8'h00, 8'h07}, '{OP_RD, 8'h00, 8'h00},
      '{OP_SET, 8'hFF, 8'h00}, '{OP_WR, 8'h11, 8'h00}, '{OP_WR, 8'h22, 8'h00},
      '{OP_SET, 8'hFF, 8'h00}, '{OP_RD, 8'h00, 8'h11}, '{OP_RD, 8'h00, 8'h22}
    };

    ptr_m = '0;
    #12;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_run_cycles", 32'(run_cycles), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_host_ready", 32'(host_ready), 32'd1);

    // Fill the whole RAM so every later read has a known model value.
    host_cmd(OP_SET, 8'h00, 0, rd);
    for (int i = 0; i < 256; i++) host_cmd(OP_WR, 8'($urandom), 0, rd);
    check("fill_ptr_wrap", 32'(ptr_m), 32'd0);

    for (int i = 0; i < 15; i++) begin
      host_cmd(vecs[i].op, vecs[i].wd, 0, rd);
      if (vecs[i].op == OP_RD) check("table_rd", 32'(rd), 32'(vecs[i].exp));
    end
    cpu_adr = 8'hFF; #1;
    check("cpu_memdata_ff", 32'(cpu_memdata), 32'h11);

    // RUN ignores host writes; core store lands; pointer untouched.
    host_cmd(OP_SET, 8'h30, 0, rd);
    host_cmd(OP_WR, 8'h33, 0, rd);
    host_cmd(OP_SET, 8'h30, 0, rd);
    host_cmd(OP_RUN, 8'h00, 0, rd);
    host_valid = 1'b1; host_op = OP_WR; host_wdata = 8'h99;
    cpu_adr = 8'h40; cpu_writedata = 8'h5A; cpu_memwrite = 1'b1;
    @(posedge clk); #1;
    mem_m[8'h40] = 8'h5A;
    cpu_memwrite = 1'b0;
    check("poke_ready", 32'(host_ready), 32'd0);
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0; host_valid = 1'b0;
    check("t3_run_cycles", 32'(run_cycles), 32'd2);
    host_cmd(OP_RD, 8'h00, 0, rd);
    check("t3_no_host_write", 32'(rd), 32'h33);
    host_cmd(OP_SET, 8'h40, 0, rd);
    host_cmd(OP_RD, 8'h00, 0, rd);
    check("t3_core_store", 32'(rd), 32'h5A);

    // Stalled response: held stable, pointer advanced once.
    host_cmd(OP_SET, 8'h01, 0, rd);
    host_cmd(OP_RD, 8'h00, 5, rd);
    check("t4_rd", 32'(rd), 32'h07);
    host_cmd(OP_RD, 8'h00, 0, rd);
    check("t4_ptr_once", 32'(rd), 32'h00);

    // halt with simultaneous store, plus host pokes throughout a longer run.
    do_run(7, 1'b0, 1'b1, 1'b1);
    cpu_adr = 8'h10; #1;
    check("t5_store", 32'(cpu_memdata), 32'hA5);

    // Reset mid-RUN.
    host_cmd(OP_RUN, 8'h00, 0, rd);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b0; #1;
    check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t6_running", 32'(running), 32'd0);
    check("t6_run_cycles", 32'(run_cycles), 32'd0);
    ptr_m = '0;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    host_cmd(OP_RD, 8'h00, 0, rd);
    check("t6_ptr0", 32'(rd), 32'h22);
    host_cmd(OP_RD, 8'h00, 0, rd);
    check("t6_b1", 32'(rd), 32'h07);
    host_cmd(OP_RD, 8'h00, 0, rd);
    check("t6_b2", 32'(rd), 32'h00);
    host_cmd(OP_RD, 8'h00, 0, rd);
    check("t6_b3", 32'(rd), 32'h80);

    // Reset mid-RDRSP drops the pending response.
    host_valid = 1'b1; host_op = OP_RD;
    @(posedge clk); #1;
    host_valid = 1'b0;
    check("t6b_valid", 32'(rsp_valid), 32'd1);
    reset_n = 1'b0; #1;
    check("t6b_drop", 32'(rsp_valid), 32'd0);
    check("t6b_data", 32'(rsp_data), 32'd0);
    ptr_m = '0;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("t6b_ready", 32'(host_ready), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    host_cmd(OP_SET, 8'($urandom), 0, rd);
        2, 3, 4: host_cmd(OP_WR, 8'($urandom), 0, rd);
        5, 6, 7: host_cmd(OP_RD, 8'h00, $urandom_range(0, 2), rd);
        8: begin
          cpu_adr = 8'($urandom); #1;
          check("cpu_memdata_hold", 32'(cpu_memdata), 32'(mem_m[cpu_adr]));
          @(posedge clk); #1;
        end
        default: do_run($urandom_range(1, 10), 1'b1, ($urandom_range(0, 1) == 1), 1'b0);
      endcase
    end

    // Final dump of a window of RAM through the host port.
    first = 8'($urandom);
    limit = 32;
    host_cmd(OP_SET, first, 0, rd);
    for (int i = 0; i < limit; i++) host_cmd(OP_RD, 8'h00, 0, rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
